// File: rtl/bus_dma_master.sv
// bus_dma_master: block-copy bus master for one master port of the shared bus.
// On an accepted start it requests the bus. Once granted, it copies `length`
// 32-bit words from src_addr.. to dst_addr.. (8-bit wrapping addresses). Each
// word is copied as a read (RD, CAP) followed by a write (WR). If the grant is
// lost mid-word, that word is abandoned and restarted after the bus is regranted.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle copy request, honoured only in IDLE
//   src_addr, dst_addr    first source / destination word address
//   length                word count (0..255)
//   busy, done            activity flag and one-cycle completion pulse
//   m_req, m_grant        arbiter handshake
//   m_wr, m_address       bus command and address
//   m_dout, m_din         bus write data / read data (read data valid the cycle after the address)
module bus_dma_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  src_addr,
  input  logic [7:0]  dst_addr,
  input  logic [7:0]  length,
  output logic        busy,
  output logic        done,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_wr,
  output logic [7:0]  m_address,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [AW-1:0]   src_q;
  logic [AW-1:0]   dst_q;
  logic [AW-1:0]   len_q;
  logic [AW-1:0]   idx;
  logic [DW-1:0]   data_buf;

  logic [AW-1:0]   idx_inc;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic            last_word;

  // Word address arithmetic wraps modulo 256.
  assign idx_inc   = AW'(idx + AW'(1));
  assign rd_addr   = AW'(src_q + idx);
  assign wr_addr   = AW'(dst_q + idx);
  assign last_word = (idx_inc == len_q);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A grant loss in RD/CAP/WR falls back to REQ and restarts the word.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (length == AW'(0)) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (m_grant) begin
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        state_nxt = m_grant ? S_CAP : S_REQ;
      end
      S_CAP: begin
        state_nxt = m_grant ? S_WR : S_REQ;
      end
      S_WR: begin
        if (!m_grant) begin
          state_nxt = S_REQ;
        end else if (last_word) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state and counters only.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_address = '0;
    m_dout    = '0;
    unique case (state)
      S_IDLE: begin
      end
      S_REQ: begin
        busy  = 1'b1;
        m_req = 1'b1;
      end
      S_RD, S_CAP: begin
        busy      = 1'b1;
        m_req     = 1'b1;
        m_address = rd_addr;
      end
      S_WR: begin
        busy      = 1'b1;
        m_req     = 1'b1;
        m_wr      = 1'b1;
        m_address = wr_addr;
        m_dout    = data_buf;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Copy parameters, word index and data buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      data_buf <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            len_q    <= length;
            idx      <= '0;
            data_buf <= '0;
          end
        end
        S_RD: begin
          if (!m_grant) begin
            data_buf <= '0;
          end
        end
        S_CAP: begin
          // Read data is valid in CAP, one cycle after the address in RD.
          data_buf <= m_grant ? m_din : DW'(0);
        end
        S_WR: begin
          // A write presented without grant is not counted.
          if (m_grant) begin
            idx <= idx_inc;
          end else begin
            data_buf <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a simple one-cycle-latency memory slave.
module tb_bus_dma_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [7:0]  m_address;
  logic [31:0] m_dout;
  logic [31:0] m_din;

  logic [31:0] mem [256];
  int          wr_count;
  int          n_cmp;
  int          n_err;
  int          cyc;

  bus_dma_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .m_req     (m_req),
    .m_grant   (m_grant),
    .m_wr      (m_wr),
    .m_address (m_address),
    .m_dout    (m_dout),
    .m_din     (m_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: registered read data, writes accepted only while granted.
  always @(posedge clk) begin
    if (m_req && !m_wr) m_din <= mem[m_address];
    if (m_req && m_wr && m_grant) begin
      mem[m_address] <= m_dout;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Pulse start for one cycle; returns at the negedge of cycle 1.
  task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    length   = l;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " m_req"}, 32'(m_req), 32'd0);
    check({tag, " m_wr"},  32'(m_wr), 32'd0);
    check({tag, " addr"},  32'(m_address), 32'd0);
    check({tag, " dout"},  m_dout, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_data [3];
    int          w;
    n_cmp = 0; n_err = 0; wr_count = 0; cyc = 0;
    m_din = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; m_grant = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic copy 00..02 -> 80..82, grant tied high.
    mem[8'h00] = 32'h1111_1111; mem[8'h01] = 32'h2222_2222; mem[8'h02] = 32'h3333_3333;
    exp_data[0] = 32'h1111_1111; exp_data[1] = 32'h2222_2222; exp_data[2] = 32'h3333_3333;
    wr_count = 0;
    do_start(8'h00, 8'h80, 8'd3);
    for (int c = 1; c <= 12; c++) begin
      w = (c - 2) / 3;
      check($sformatf("basic c%0d busy", c), 32'(busy), 32'(c <= 11));
      check($sformatf("basic c%0d done", c), 32'(done), 32'(c == 11));
      check($sformatf("basic c%0d m_req", c), 32'(m_req), 32'(c <= 10));
      check($sformatf("basic c%0d m_wr", c), 32'(m_wr), 32'(c == 4 || c == 7 || c == 10));
      if (c >= 2 && c <= 10 && (c - 2) % 3 != 2)
        check($sformatf("basic c%0d rd addr", c), 32'(m_address), 32'(w));
      if (c == 4 || c == 7 || c == 10) begin
        check($sformatf("basic c%0d wr addr", c), 32'(m_address), 32'(8'h80 + w));
        check($sformatf("basic c%0d wr data", c), m_dout, exp_data[w]);
      end else begin
        check($sformatf("basic c%0d dout idle", c), m_dout, 32'd0);
      end
      step();
    end
    check("basic mem80", mem[8'h80], 32'h1111_1111);
    check("basic mem81", mem[8'h81], 32'h2222_2222);
    check("basic mem82", mem[8'h82], 32'h3333_3333);
    check("basic wr_count", 32'(wr_count), 32'd3);

    // Zero length: single busy+done cycle, never requests the bus.
    do_start(8'h05, 8'h06, 8'd0);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("zero c%0d busy", c), 32'(busy), 32'(c == 1));
      check($sformatf("zero c%0d done", c), 32'(done), 32'(c == 1));
      check($sformatf("zero c%0d m_req", c), 32'(m_req), 32'd0);
      step();
    end

    // Grant delay and loss: 5 cycles without grant, then grant dropped in CAP of word 1.
    mem[8'h10] = 32'hA1A1_0001; mem[8'h11] = 32'hA2A2_0002; mem[8'h12] = 32'hA3A3_0003;
    wr_count = 0;
    m_grant = 1'b0;
    do_start(8'h10, 8'h20, 8'd3);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("gnt c%0d m_req", c), 32'(m_req), 32'd1);
      check($sformatf("gnt c%0d no rd", c), 32'(m_address), 32'd0);
      if (c == 5) m_grant = 1'b1;
      step();
    end
    check("gnt c6 rd addr", 32'(m_address), 32'h10);
    repeat (4) step();
    check("gnt c10 cap addr", 32'(m_address), 32'h11);
    check("gnt c10 m_wr", 32'(m_wr), 32'd0);
    m_grant = 1'b0;
    step();
    check("gnt c11 back to req", 32'(m_req), 32'd1);
    check("gnt c11 req addr", 32'(m_address), 32'd0);
    check("gnt c11 busy", 32'(busy), 32'd1);
    m_grant = 1'b1;
    step();
    check("gnt c12 reread addr", 32'(m_address), 32'h11);
    repeat (6) step();
    check("gnt c18 done", 32'(done), 32'd1);
    step();
    check("gnt c19 busy", 32'(busy), 32'd0);
    check("gnt mem20", mem[8'h20], 32'hA1A1_0001);
    check("gnt mem21", mem[8'h21], 32'hA2A2_0002);
    check("gnt mem22", mem[8'h22], 32'hA3A3_0003);
    check("gnt wr_count", 32'(wr_count), 32'd3);

    // Wrap with overlap: the write to FF lands before FF is read, so all three writes carry W0.
    mem[8'hFE] = 32'hCAFE_0000; mem[8'hFF] = 32'hCAFE_0001; mem[8'h00] = 32'hCAFE_0002;
    do_start(8'hFE, 8'hFF, 8'd3);
    for (int c = 1; c <= 11; c++) begin
      if (c == 2) check("wrap rd0", 32'(m_address), 32'hFE);
      if (c == 5) check("wrap rd1", 32'(m_address), 32'hFF);
      if (c == 8) check("wrap rd2", 32'(m_address), 32'h00);
      if (c == 4)  begin check("wrap wr0 addr", 32'(m_address), 32'hFF); check("wrap wr0 data", m_dout, 32'hCAFE_0000); end
      if (c == 7)  begin check("wrap wr1 addr", 32'(m_address), 32'h00); check("wrap wr1 data", m_dout, 32'hCAFE_0000); end
      if (c == 10) begin check("wrap wr2 addr", 32'(m_address), 32'h01); check("wrap wr2 data", m_dout, 32'hCAFE_0000); end
      if (c == 11) check("wrap done", 32'(done), 32'd1);
      step();
    end

    // Start while busy is ignored.
    mem[8'h30] = 32'hC1C1_C1C1; mem[8'h31] = 32'hC2C2_C2C2; mem[8'h50] = 32'hDEAD_BEEF;
    mem[8'h60] = 32'h0; mem[8'h40] = 32'h0; mem[8'h41] = 32'h0;
    wr_count = 0;
    do_start(8'h30, 8'h40, 8'd2);
    repeat (3) step();
    check("busy c4 m_wr", 32'(m_wr), 32'd1);
    start = 1'b1; src_addr = 8'h50; dst_addr = 8'h60; length = 8'd5;
    step();
    start = 1'b0;
    check("busy c5 rd addr", 32'(m_address), 32'h31);
    repeat (3) step();
    check("busy c8 done", 32'(done), 32'd1);
    step();
    check("busy c9 idle", 32'(busy), 32'd0);
    step();
    check("busy c10 not restarted", 32'(busy), 32'd0);
    check("busy mem40", mem[8'h40], 32'hC1C1_C1C1);
    check("busy mem41", mem[8'h41], 32'hC2C2_C2C2);
    check("busy mem60 untouched", mem[8'h60], 32'h0);
    check("busy wr_count", 32'(wr_count), 32'd2);

    // Reset asserted during WR aborts the write.
    mem[8'h90] = 32'h0;
    wr_count = 0;
    do_start(8'h00, 8'h90, 8'd2);
    repeat (3) step();
    check("rst c4 m_wr", 32'(m_wr), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rst mid-wr");
    step();
    check_idle_outputs("rst held");
    reset_n = 1'b1;
    step();
    check_idle_outputs("rst released");
    check("rst mem90", mem[8'h90], 32'h0);
    check("rst wr_count", 32'(wr_count), 32'd0);

    // Fresh copy after reset confirms IDLE and cleared state.
    do_start(8'h80, 8'hA0, 8'd1);
    repeat (3) step();
    check("post-rst wr addr", 32'(m_address), 32'hA0);
    check("post-rst wr data", m_dout, 32'h1111_1111);
    step();
    check("post-rst done", 32'(done), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
